// File: rtl/wired_dsram_arb.sv
// wired_dsram_arb: single-port dcache data/tag SRAM arbiter.
// Shares the port among refill, store drain and LSU reads; drives snoop.
module wired_dsram_arb #(
   parameter int TAG_W      = 22,
   parameter int STARVE_MAX = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_valid_i,
   output logic                   rd_ready_o,
   input  logic [11:0]            rd_addr_i,
   output logic                   rd_resp_valid_o,
   output logic [3:0][31:0]       rd_data_o,
   output logic [3:0][TAG_W-1:0]  rd_tag_o,
   input  logic                   sb_valid_i,
   output logic                   sb_ready_o,
   input  logic [11:0]            sb_addr_i,
   input  logic [3:0]             sb_way_i,
   input  logic [3:0]             sb_strb_i,
   input  logic [31:0]            sb_wdata_i,
   input  logic                   rf_valid_i,
   output logic                   rf_ready_o,
   input  logic [11:0]            rf_addr_i,
   input  logic [3:0]             rf_way_i,
   input  logic [31:0]            rf_wdata_i,
   input  logic [TAG_W-1:0]       rf_tag_i,
   output logic [11:0]            sram_addr_o,
   output logic                   sram_en_o,
   output logic [3:0][3:0]        sram_dwe_o,
   output logic [31:0]            sram_wdata_o,
   output logic [3:0]             sram_twe_o,
   output logic [TAG_W-1:0]       sram_tag_o,
   input  logic [3:0][31:0]       sram_rdata_i,
   input  logic [3:0][TAG_W-1:0]  sram_rtag_i,
   output logic [11:0]            snoop_daddr_o,
   output logic [1:0]             snoop_dway_o,
   output logic [3:0][31:0]       snoop_d_o,
   output logic [3:0][3:0]        snoop_dstrb_o,
   output logic [11:0]            snoop_taddr_o,
   output logic [3:0]             snoop_twe_o,
   output logic [TAG_W-1:0]       snoop_t_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic {
      S_IDLE,
      S_REFILL
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [1:0]     beat_q;
   logic [1:0]     beat_d;
   logic [SW-1:0]  starve_q;
   logic [SW-1:0]  starve_d;

   logic           rf_gnt;
   logic           sb_gnt;
   logic           rd_gnt;
   logic           rd_pri;
   logic           wr_gnt;
   logic [1:0]     beat;
   logic [3:0]     wr_way;
   logic [3:0]     wr_strb;

   // line-address low bits are implied by the beat counter
   logic           unused_rf_lo;
   assign unused_rf_lo = ^rf_addr_i[3:0];

   // state, beat counter, starvation counter and read response flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         beat_q          <= 2'd0;
         starve_q        <= '0;
         rd_resp_valid_o <= 1'b0;
      end else begin
         state_q         <= state_d;
         beat_q          <= beat_d;
         starve_q        <= starve_d;
         rd_resp_valid_o <= rd_gnt;
      end
   end

   // arbitration and refill sequencing
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      rf_gnt  = 1'b0;
      sb_gnt  = 1'b0;
      rd_gnt  = 1'b0;
      rd_pri  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rd_pri = rd_valid_i && (starve_q >= STARVE_LIM);
            if (rf_valid_i) begin
               rf_gnt  = 1'b1;
               state_d = S_REFILL;
               beat_d  = 2'd1;
            end else if (rd_pri) begin
               rd_gnt = 1'b1;
            end else if (sb_valid_i) begin
               sb_gnt = 1'b1;
            end else if (rd_valid_i) begin
               rd_gnt = 1'b1;
            end
         end
         S_REFILL: begin
            if (rf_valid_i) begin
               rf_gnt = 1'b1;
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_d = S_IDLE;
               end
            end else if (rd_valid_i) begin
               rd_gnt = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = 2'd0;
         end
      endcase
   end

   // starvation counter: saturates while a read waits, clears on grant
   always_comb begin
      starve_d = starve_q;
      if (rd_gnt) begin
         starve_d = '0;
      end else if (rd_valid_i && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign beat   = (state_q == S_REFILL) ? beat_q : 2'd0;
   assign wr_gnt = rf_gnt | sb_gnt;

   // SRAM address, write word, way/strobe and tag-write select
   always_comb begin
      sram_addr_o  = rd_addr_i;
      sram_wdata_o = sb_wdata_i;
      sram_twe_o   = 4'h0;
      wr_way       = 4'h0;
      wr_strb      = 4'h0;
      if (rf_gnt) begin
         sram_addr_o  = {rf_addr_i[11:4], beat, 2'b00};
         sram_wdata_o = rf_wdata_i;
         wr_way       = rf_way_i;
         wr_strb      = 4'hF;
         if (beat == 2'd3) begin
            sram_twe_o = rf_way_i;
         end
      end else if (sb_gnt) begin
         sram_addr_o = sb_addr_i;
         wr_way      = sb_way_i;
         wr_strb     = sb_strb_i;
      end
   end

   // per-way byte enables and per-slot snoop strobes
   always_comb begin
      for (int w = 0; w < 4; w++) begin
         sram_dwe_o[w]    = wr_way[w] ? wr_strb : 4'h0;
         snoop_dstrb_o[w] = 4'h0;
         if (wr_gnt && (sram_addr_o[3:2] == 2'(w))) begin
            snoop_dstrb_o[w] = wr_strb;
         end
      end
   end

   // encoded way of the data write for the snoop bus
   always_comb begin
      snoop_dway_o = 2'd0;
      unique case (1'b1)
         wr_way[0]: snoop_dway_o = 2'd0;
         wr_way[1]: snoop_dway_o = 2'd1;
         wr_way[2]: snoop_dway_o = 2'd2;
         wr_way[3]: snoop_dway_o = 2'd3;
         default:   snoop_dway_o = 2'd0;
      endcase
   end

   assign rd_ready_o    = rd_gnt;
   assign sb_ready_o    = sb_gnt;
   assign rf_ready_o    = rf_gnt;
   assign sram_en_o     = rf_gnt | sb_gnt | rd_gnt;
   assign sram_tag_o    = rf_tag_i;
   assign rd_data_o     = sram_rdata_i;
   assign rd_tag_o      = sram_rtag_i;
   assign snoop_daddr_o = sram_addr_o;
   assign snoop_d_o     = {4{sram_wdata_o}};
   assign snoop_taddr_o = sram_addr_o;
   assign snoop_twe_o   = sram_twe_o;
   assign snoop_t_o     = rf_tag_i;

   a_rf_way_onehot: assert property (
      @(posedge clk) disable iff (rst)
      rf_valid_i |-> $onehot(rf_way_i));

   a_sb_way_onehot: assert property (
      @(posedge clk) disable iff (rst)
      sb_valid_i |-> $onehot(sb_way_i));

   a_one_grant: assert property (
      @(posedge clk) disable iff (rst)
      $onehot0({rf_gnt, sb_gnt, rd_gnt}));

   a_no_sb_in_refill: assert property (
      @(posedge clk) disable iff (rst)
      (state_q == S_REFILL) |-> !sb_gnt);

   a_twe_last_beat: assert property (
      @(posedge clk) disable iff (rst)
      (|sram_twe_o) |-> (state_q == S_REFILL && beat_q == 2'd3));

endmodule
